serial_adder: RTL and testbench

- Bit-serial W-bit adder built around a single 1-bit full-adder cell with a registered carry.
- Accepts two parallel operands plus carry-in on a start pulse, then feeds the cell one bit pair per clock, LSB first.
- Collects the sum bits into a result register and signals completion with a one-cycle done pulse.
- Serves as the sequential stage that drives the full-adder cell and consumes its z/co outputs; it is the area-minimal alternative to a ripple-carry adder.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_adder.sv | 83 ++++++++
 tb/tb_serial_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 8;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder cell; zero latency, no flow control.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic z,
  output logic co
);

  assign z  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell, LSB first, result after W+1 cycles.
// Start is only honoured in IDLE or DONE; requests while busy are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         co
);

  localparam int              CW   = $clog2(W + 1);
  localparam logic [CW-1:0]   LAST = CW'(W - 1);

  state_t         state;
  logic [W-1:0]   sa;
  logic [W-1:0]   sb;
  logic           c;
  logic [CW-1:0]  cnt;
  logic           fa_z;
  logic           fa_co;

  full_adder_bit u_fa (
    .x  (sa[0]),
    .y  (sb[0]),
    .ci (c),
    .z  (fa_z),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      co    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            c     <= ci;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands in bit 0 after W shifts.
          sum <= (sum >> 1) | (W'(fa_z) << (W - 1));
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= fa_co;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            co    <= fa_co;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded random/directed bench for serial_adder at W=8, W=4 and W=1.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // W=8 instance
  logic       s8 = 0, ci8 = 0, busy8, done8, co8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic [8:0] q8[$];
  // W=4 instance
  logic       s4 = 0, ci4 = 0, busy4, done4, co4;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic [4:0] q4[$];
  // W=1 instance
  logic       s1 = 0, ci1 = 0, busy1, done1, co1;
  logic [0:0] a1 = 0, b1 = 0, sum1;
  logic [1:0] q1[$];

  serial_adder #(.W(8)) dut8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .ci(ci8),
                              .busy(busy8), .done(done8), .sum(sum8), .co(co8));
  serial_adder #(.W(4)) dut4 (.clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .ci(ci4),
                              .busy(busy4), .done(done4), .sum(sum4), .co(co4));
  serial_adder #(.W(1)) dut1 (.clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .ci(ci1),
                              .busy(busy1), .done(done1), .sum(sum1), .co(co1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done8) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_err++;
        $display("FAIL res8: unexpected done, got %0h expected none", {co8, sum8});
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        if ({co8, sum8} !== e) begin
          n_err++;
          $display("FAIL res8: got %0h expected %0h", {co8, sum8}, e);
        end
      end
    end
    if (done4) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_err++;
        $display("FAIL res4: unexpected done, got %0h expected none", {co4, sum4});
      end else begin
        logic [4:0] e;
        e = q4.pop_front();
        if ({co4, sum4} !== e) begin
          n_err++;
          $display("FAIL res4: got %0h expected %0h", {co4, sum4}, e);
        end
      end
    end
    if (done1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL res1: unexpected done, got %0h expected none", {co1, sum1});
      end else begin
        logic [1:0] e;
        e = q1.pop_front();
        if ({co1, sum1} !== e) begin
          n_err++;
          $display("FAIL res1: got %0h expected %0h", {co1, sum1}, e);
        end
      end
    end
  end

  // Issues a W=8 start; on return the bench sits in cycle 1 (first RUN cycle).
  task automatic start8(input logic [7:0] ta, input logic [7:0] tb_, input logic tci);
    a8 = ta; b8 = tb_; ci8 = tci; s8 = 1'b1;
    q8.push_back(9'(ta) + 9'(tb_) + 9'(tci));
    tick();
    s8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tci);
    start8(ta, tb_, tci);
    for (int k = 1; k <= 8; k++) begin
      chk("busy8_run", 32'(busy8), 32'd1);
      chk("done8_run", 32'(done8), 32'd0);
      tick();
    end
    chk("done8_pulse", 32'(done8), 32'd1);
    chk("busy8_in_done", 32'(busy8), 32'd0);
    tick();
    chk("done8_single", 32'(done8), 32'd0);
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tci);
    int n;
    a4 = ta; b4 = tb_; ci4 = tci; s4 = 1'b1;
    q4.push_back(5'(ta) + 5'(tb_) + 5'(tci));
    tick();
    s4 = 1'b0;
    n = 0;
    while (!done4 && n < 10) begin
      tick();
      n++;
    end
    chk("done4_seen", 32'(done4), 32'd1);
    chk("lat4", 32'(n), 32'd4);
    tick();
  endtask

  task automatic op1(input logic ta, input logic tb_, input logic tci);
    a1 = ta; b1 = tb_; ci1 = tci; s1 = 1'b1;
    q1.push_back(2'(ta) + 2'(tb_) + 2'(tci));
    tick();
    s1 = 1'b0;
    chk("busy1_run", 32'(busy1), 32'd1);
    tick();
    chk("done1_pulse", 32'(done1), 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_co", 32'(co8), 32'd0);

    op8(8'h0F, 8'h01, 1'b0);
    chk("hold_sum", 32'(sum8), 32'h10);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
    chk("hold_co", 32'(co8), 32'd1);

    // Start and operand changes while busy must be ignored.
    start8(8'h12, 8'h34, 1'b0);
    tick(); tick();
    s8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1;
    tick();
    s8 = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("ign_sum", 32'(sum8), 32'h46);
    chk("ign_busy", 32'(busy8), 32'd0);
    chk("ign_q", 32'(q8.size()), 32'd0);

    // Reset in the middle of a run abandons it.
    start8(8'h33, 8'h44, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    q8.delete();
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy8), 32'd0);
    chk("mrst_done", 32'(done8), 32'd0);
    chk("mrst_sum", 32'(sum8), 32'd0);
    chk("mrst_co", 32'(co8), 32'd0);
    for (int k = 0; k < 12; k++) tick();

    // Back-to-back: start held through the DONE cycle.
    start8(8'h01, 8'h02, 1'b0);
    for (int k = 0; k < 8; k++) tick();
    chk("b2b_done1", 32'(done8), 32'd1);
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; s8 = 1'b1;
    q8.push_back(9'h100);
    tick();
    s8 = 1'b0;
    chk("b2b_busy", 32'(busy8), 32'd1);
    for (int k = 0; k < 8; k++) tick();
    chk("b2b_done2", 32'(done8), 32'd1);
    chk("b2b_res", 32'({co8, sum8}), 32'h100);
    tick();

    for (int i = 0; i < 150; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      op4(v[3:0], v[7:4], v[8]);
    end

    op1(1'b1, 1'b1, 1'b1);
    chk("w1_sum", 32'(sum1), 32'd1);
    chk("w1_co", 32'(co1), 32'd1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[0], v[1], v[2]);
    end

    tick(); tick();
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
